// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, decode payload
// field offsets, div_op bit meanings and divider state encodings.
package exe_stage_pkg;

    localparam int DS_ES_W  = 151;
    localparam int ES_MS_W  = 71;
    localparam int ES_FWD_W = 39;

    // ds_es_bus field offsets (LSB of each field)
    localparam int DS_PC_LSB     = 119;
    localparam int DS_ALU_OP_LSB = 107;
    localparam int DS_SRC1_LSB   = 75;
    localparam int DS_SRC2_LSB   = 43;
    localparam int DS_RKD_LSB    = 11;
    localparam int DS_GR_WE      = 10;
    localparam int DS_DEST_LSB   = 5;
    localparam int DS_MEM_WE     = 4;
    localparam int DS_RES_MEM    = 3;
    localparam int DS_DIV_OP_LSB = 0;

    // div_op bit indices
    localparam int DIV_OP_EN     = 2;
    localparam int DIV_OP_SIGNED = 1;
    localparam int DIV_OP_MOD    = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline-facing signals of the execute stage: decode handshake, memory
// stage handshake, forwarding bus and the data SRAM request.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                ds_to_es_valid;
    logic                es_allow_in;
    logic [DS_ES_W-1:0]  ds_es_bus;
    logic                ms_allow_in;
    logic                es_to_ms_valid;
    logic [ES_MS_W-1:0]  es_ms_bus;
    logic [ES_FWD_W-1:0] es_fwd_bus;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;

    // Environment side (decode, memory stage, SRAM)
    modport master (
        output ds_to_es_valid, ds_es_bus, ms_allow_in,
        input  es_allow_in, es_to_ms_valid, es_ms_bus, es_fwd_bus,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    // Execute stage side
    modport slave (
        input  ds_to_es_valid, ds_es_bus, ms_allow_in,
        output es_allow_in, es_to_ms_valid, es_ms_bus, es_fwd_bus,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU. alu_op is one-hot:
// 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
// 8 sll, 9 srl, 10 sra, 11 lui (passes src2, already shifted by decode).
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    // OR together the results of every selected operation
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result |= alu_src1 + alu_src2;
        if (alu_op[1])  alu_result |= alu_src1 - alu_src2;
        if (alu_op[2])  alu_result |= {31'd0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[3])  alu_result |= {31'd0, alu_src1 < alu_src2};
        if (alu_op[4])  alu_result |= alu_src1 & alu_src2;
        if (alu_op[5])  alu_result |= ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result |= alu_src1 | alu_src2;
        if (alu_op[7])  alu_result |= alu_src1 ^ alu_src2;
        if (alu_op[8])  alu_result |= alu_src1 << alu_src2[4:0];
        if (alu_op[9])  alu_result |= alu_src1 >> alu_src2[4:0];
        if (alu_op[10]) alu_result |= $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
        if (alu_op[11]) alu_result |= alu_src2;
    end

endmodule

// File: rtl/es_divider.sv
// Iterative restoring divider for div/mod instructions.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  DIV_IDLE | waiting for a divide; operands latched as magnitudes on start
//  DIV_BUSY | one restoring iteration per cycle, DIV_CYCLES iterations
//  DIV_FIX  | apply signs / divide-by-zero result, register it, raise done
module es_divider
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic        op_mod,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clear,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, div_mag;
    logic        neg_q, neg_r, b_zero, mod_q;

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] q_fix, r_fix;

    // Trial subtraction: shift in the next dividend bit and compare
    assign shifted = {rem, quo[31]};
    assign fits    = shifted >= {1'b0, div_mag};
    assign diff    = shifted[31:0] - div_mag;

    // Divide by zero returns all-ones quotient; remainder restores to the dividend
    assign q_fix = b_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
    assign r_fix = neg_r ? (~rem + 32'd1) : rem;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start && !done) state_d = DIV_BUSY;
            DIV_BUSY: if (cnt == 6'(DIV_CYCLES - 1)) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 6'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            div_mag <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            mod_q   <= 1'b0;
            result  <= 32'd0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start && !done) begin
                        cnt     <= 6'd0;
                        rem     <= 32'd0;
                        quo     <= abs32(a, is_signed);
                        div_mag <= abs32(b, is_signed);
                        neg_q   <= is_signed && (a[31] ^ b[31]);
                        neg_r   <= is_signed && a[31];
                        b_zero  <= (b == 32'd0);
                        mod_q   <= op_mod;
                    end
                end
                DIV_BUSY: begin
                    rem <= fits ? diff : shifted[31:0];
                    quo <= {quo[30:0], fits};
                    cnt <= cnt + 6'd1;
                end
                DIV_FIX: begin
                    result <= mod_q ? r_fix : q_fix;
                    done   <= 1'b1;
                end
                default: ;
            endcase
            if (clear) done <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode payload, computes the ALU or divider
// result, issues the data SRAM request on transfer and drives the
// memory-stage and forwarding buses.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  pipe
);

    logic               es_valid;
    logic [DS_ES_W-1:0] payload;

    logic [31:0] pc, src1, src2, rkd_value, alu_result, div_result, result;
    logic [11:0] alu_op;
    logic [4:0]  dest;
    logic [2:0]  div_op;
    logic        gr_we, mem_we, res_from_mem;
    logic        div_done, es_ready_go, es_xfer;

    assign pc           = payload[DS_PC_LSB +: 32];
    assign alu_op       = payload[DS_ALU_OP_LSB +: 12];
    assign src1         = payload[DS_SRC1_LSB +: 32];
    assign src2         = payload[DS_SRC2_LSB +: 32];
    assign rkd_value    = payload[DS_RKD_LSB +: 32];
    assign gr_we        = payload[DS_GR_WE];
    assign dest         = payload[DS_DEST_LSB +: 5];
    assign mem_we       = payload[DS_MEM_WE];
    assign res_from_mem = payload[DS_RES_MEM];
    assign div_op       = payload[DS_DIV_OP_LSB +: 3];

    assign es_ready_go         = !div_op[DIV_OP_EN] || div_done;
    assign pipe.es_allow_in    = !es_valid || (es_ready_go && pipe.ms_allow_in);
    assign pipe.es_to_ms_valid = es_valid && es_ready_go;
    assign es_xfer             = es_valid && es_ready_go && pipe.ms_allow_in;

    // Valid bit advances whenever the stage can accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 es_valid <= 1'b0;
        else if (pipe.es_allow_in) es_valid <= pipe.ds_to_es_valid;
    end

    // Payload captured only for an accepted instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         payload <= '0;
        else if (pipe.ds_to_es_valid && pipe.es_allow_in)  payload <= pipe.ds_es_bus;
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    es_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid && div_op[DIV_OP_EN]),
        .is_signed (div_op[DIV_OP_SIGNED]),
        .op_mod    (div_op[DIV_OP_MOD]),
        .a         (src1),
        .b         (src2),
        .clear     (es_xfer),
        .done      (div_done),
        .result    (div_result)
    );

    assign result = div_op[DIV_OP_EN] ? div_result : alu_result;

    assign pipe.es_ms_bus  = {pc, gr_we, dest, result, res_from_mem};
    // Forwarded result is only final once es_ready_go is high; decode gates on that
    assign pipe.es_fwd_bus = {es_valid && gr_we, es_valid && res_from_mem, dest, result};

    // Single SRAM request, issued in the transfer cycle only
    assign pipe.data_sram_en    = es_xfer && (mem_we || res_from_mem);
    assign pipe.data_sram_we    = (pipe.data_sram_en && mem_we) ? 4'hF : 4'h0;
    assign pipe.data_sram_addr  = alu_result;
    assign pipe.data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized
// ALU/divide instructions against an arithmetic reference model.
module tb_exe_stage;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    exe_stage_if ifc ();

    exe_stage dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (ifc.slave)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,
    //       11 lui,12 div,13 mod,14 divu,15 modu
    function automatic logic [150:0] make_bus(input logic [31:0] pc, input int kind,
                                              input logic [31:0] s1, input logic [31:0] s2,
                                              input logic [31:0] rkd, input logic gr_we,
                                              input logic [4:0] dest, input logic mem_we,
                                              input logic rfm);
        logic [11:0] op;
        logic [2:0]  dop;
        op  = (kind < 12) ? (12'd1 << kind) : 12'd0;
        dop = 3'd0;
        case (kind)
            12: dop = 3'b110;
            13: dop = 3'b111;
            14: dop = 3'b100;
            15: dop = 3'b101;
            default: dop = 3'b000;
        endcase
        return {pc, op, s1, s2, rkd, gr_we, dest, mem_we, rfm, dop};
    endfunction

    function automatic logic [31:0] ref_model(input int kind, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (kind)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'(sa >>> b[4:0]);
            11: return b;
            12, 13: begin
                if (b == 0) return (kind == 12) ? 32'hFFFF_FFFF : a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (kind == 12) ? 32'h8000_0000 : 32'd0;
                return (kind == 12) ? 32'(sa / sb) : 32'(sa % sb);
            end
            14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            15: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Present one instruction for one cycle; returns at the negedge of its cycle 0
    task automatic issue(input logic [150:0] b);
        @(negedge clk);
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_es_bus      = b;
        @(negedge clk);
        ifc.ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!ifc.es_to_ms_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Run one non-memory instruction with ms_allow_in high and check everything
    task automatic do_op(input string tag, input int kind, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest);
        logic [150:0] bus;
        logic [31:0]  exp_res;
        int           exp_lat, k;
        bus     = make_bus(32'h1C00_0000 + 32'(dest) * 4, kind, a, b, 32'h0, 1'b1, dest, 1'b0, 1'b0);
        exp_res = ref_model(kind, a, b);
        exp_lat = (kind >= 12) ? 34 : 0;
        ifc.ms_allow_in = 1'b1;
        issue(bus);
        check({tag, "_fwd"}, ifc.es_fwd_bus[38:32], {1'b1, 1'b0, dest});
        wait_ready(k);
        check({tag, "_lat"}, k, exp_lat);
        check({tag, "_bus"}, ifc.es_ms_bus, {bus[150:119], bus[10], bus[9:5], exp_res, bus[3]});
        check({tag, "_allow"}, ifc.es_allow_in, 1'b1);
        @(negedge clk);
        check({tag, "_drain"}, ifc.es_to_ms_valid, 1'b0);
    endtask

    initial begin
        logic [150:0] bus, bus2;
        logic [70:0]  held;
        int           k, kind;
        logic [31:0]  a, b;

        reset              = 1'b1;
        ifc.ds_to_es_valid = 1'b0;
        ifc.ds_es_bus      = '0;
        ifc.ms_allow_in    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", ifc.es_to_ms_valid, 1'b0);
        check("rst_allow", ifc.es_allow_in, 1'b1);
        check("rst_sram", {ifc.data_sram_en, ifc.data_sram_we}, 5'd0);
        check("rst_fwd", ifc.es_fwd_bus[38:37], 2'b00);
        reset = 1'b0;

        // add 5 + 7
        do_op("add", 0, 32'd5, 32'd7, 5'd3);

        // same add, memory stage stalls for 3 cycles
        bus = make_bus(32'h1C00_0000, 0, 32'd5, 32'd7, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0);
        ifc.ms_allow_in = 1'b0;
        issue(bus);
        held = {bus[150:119], 1'b1, 5'd3, 32'd12, 1'b0};
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", ifc.es_to_ms_valid, 1'b1);
            check("stall_allow", ifc.es_allow_in, 1'b0);
            check("stall_bus", ifc.es_ms_bus, held);
            if (i < 2) @(negedge clk);
        end
        ifc.ms_allow_in = 1'b1;
        #1 check("stall_release_allow", ifc.es_allow_in, 1'b1);
        @(negedge clk);
        check("stall_drain", ifc.es_to_ms_valid, 1'b0);

        // divide corner cases
        do_op("div_neg", 12, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op("mod_neg", 13, 32'hFFFF_FFF9, 32'd2, 5'd5);
        do_op("divu_z", 14, 32'h1234, 32'd0, 5'd6);
        do_op("modu_z", 15, 32'h1234, 32'd0, 5'd7);
        do_op("div_ovf", 12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op("mod_ovf", 13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        do_op("div_sz", 12, 32'hFFFF_FFF9, 32'd0, 5'd10);
        do_op("mod_sz", 13, 32'hFFFF_FFF9, 32'd0, 5'd11);

        // store with 2 stalled cycles: one SRAM pulse at release
        bus = make_bus(32'h1C00_0040, 0, 32'hF0, 32'h10, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b0);
        ifc.ms_allow_in = 1'b0;
        issue(bus);
        check("st_stall0_en", ifc.data_sram_en, 1'b0);
        @(negedge clk);
        check("st_stall1_en", ifc.data_sram_en, 1'b0);
        ifc.ms_allow_in = 1'b1;
        #1;
        check("st_en", ifc.data_sram_en, 1'b1);
        check("st_we", ifc.data_sram_we, 4'hF);
        check("st_addr", ifc.data_sram_addr, 32'h100);
        check("st_wdata", ifc.data_sram_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("st_after_en", {ifc.data_sram_en, ifc.data_sram_we}, 5'd0);

        // load: request without write enables, load-use bit on forward bus
        bus = make_bus(32'h1C00_0044, 0, 32'h200, 32'h4, 32'h0, 1'b1, 5'd12, 1'b0, 1'b1);
        issue(bus);
        check("ld_en", {ifc.data_sram_en, ifc.data_sram_we}, 5'b1_0000);
        check("ld_addr", ifc.data_sram_addr, 32'h204);
        check("ld_fwd", ifc.es_fwd_bus[38:32], {1'b1, 1'b1, 5'd12});
        @(negedge clk);
        check("ld_after_en", ifc.data_sram_en, 1'b0);

        // back-to-back divides: second must see the full latency again
        bus  = make_bus(32'h1C00_0080, 14, 32'd100, 32'd7, 32'h0, 1'b1, 5'd13, 1'b0, 1'b0);
        bus2 = make_bus(32'h1C00_0084, 13, 32'd100, 32'hFFFF_FFF9, 32'h0, 1'b1, 5'd14, 1'b0, 1'b0);
        @(negedge clk);
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_es_bus      = bus;
        @(negedge clk);
        ifc.ds_es_bus      = bus2;
        wait_ready(k);
        check("b2b_lat1", k, 34);
        check("b2b_res1", ifc.es_ms_bus[32:1], 32'd14);
        @(negedge clk);
        ifc.ds_to_es_valid = 1'b0;
        wait_ready(k);
        check("b2b_lat2", k, 34);
        check("b2b_res2", ifc.es_ms_bus[32:1], 32'd2);
        @(negedge clk);
        check("b2b_drain", ifc.es_to_ms_valid, 1'b0);

        // reset in cycle 10 of a divide
        bus = make_bus(32'h1C00_00C0, 12, 32'd1000, 32'd3, 32'h0, 1'b1, 5'd15, 1'b0, 1'b0);
        issue(bus);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rmid_valid", ifc.es_to_ms_valid, 1'b0);
        check("rmid_allow", ifc.es_allow_in, 1'b1);
        check("rmid_fsm", dut.u_div.state_q, 2'd0);
        check("rmid_done", dut.u_div.done, 1'b0);
        check("rmid_fwd", ifc.es_fwd_bus[38:37], 2'b00);
        @(negedge clk);
        reset = 1'b0;
        do_op("rmid_add", 0, 32'h1111_0000, 32'h0000_2222, 5'd16);

        // randomized instructions
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 15);
            a    = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            do_op($sformatf("rnd%0d_k%0d", i, kind), kind, a, b, 5'($urandom_range(1, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
